io_bridge: RTL
==============

IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of CPU-to-external FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter WIDTH, default 16, data width of both directions.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cpu_out_port  input  WIDTH  word written by CPU OUT instruction.
REQ-006 SHALL have port cpu_out_we  input  1  CPU OUT strobe, one word per high cycle.
REQ-007 SHALL have port cpu_out_full  output  1  FIFO full; CPU stalls OUT while high.
REQ-008 SHALL have port cpu_in_port  output  WIDTH  word presented to CPU IN instruction.
REQ-009 SHALL have port cpu_in_re  input  1  CPU IN consume strobe.
REQ-010 SHALL have port cpu_in_empty  output  1  no valid word in input holding register.
REQ-011 SHALL have port ext_tx_data  output  WIDTH  FIFO head word to external device.
REQ-012 SHALL have port ext_tx_valid  output  1  ext_tx_data valid.
REQ-013 SHALL have port ext_tx_ready  input  1  external device accepts ext_tx_data.
REQ-014 SHALL have port ext_rx_data  input  WIDTH  word from external device.
REQ-015 SHALL have port ext_rx_valid  input  1  ext_rx_data valid.
REQ-016 SHALL have port ext_rx_ready  output  1  holding register can accept a word.
REQ-017 SHALL have port ovf_err  output  1  sticky overflow flag (see Configuration).

Function
REQ-018 TX path SHALL be a DEPTH-entry circular FIFO with wr/rd pointers of log2(DEPTH)+1 bits; full = pointers equal except MSB, empty = pointers equal.
REQ-019 Write SHALL occur when cpu_out_we && !cpu_out_full; word enters FIFO at that edge.
REQ-020 cpu_out_we while full SHALL drop the word and leave FIFO unchanged.
REQ-021 Pop SHALL occur when ext_tx_valid && ext_tx_ready; ext_tx_valid = !empty; ext_tx_data = head entry combinationally (first-word latency: 1 cycle after write).
REQ-022 Simultaneous write and pop SHALL be allowed when full (pop frees slot same cycle is NOT used: full blocks write) and when non-full/non-empty; count unchanged.
REQ-023 Pointers SHALL wrap modulo 2*DEPTH with no lost or duplicated words.
REQ-024 ext_tx_data SHALL hold stable while ext_tx_valid && !ext_tx_ready.
REQ-025 RX path SHALL be a one-entry holding register with states EMPTY and FULL.
REQ-026 EMPTY -> FULL on ext_rx_valid && ext_rx_ready, capturing ext_rx_data; ext_rx_ready = (state == EMPTY).
REQ-027 FULL -> EMPTY on cpu_in_re; cpu_in_re in EMPTY SHALL be ignored.
REQ-028 cpu_in_port SHALL show the captured word in FULL and retain last captured word in EMPTY; cpu_in_empty = (state == EMPTY).
REQ-029 TX and RX paths SHALL operate independently in the same cycle.

Reset
REQ-030 Assertion of rst (low) SHALL immediately clear FIFO pointers, RX state to EMPTY, ovf_err to 0, cpu_in_port to 0.
REQ-031 During reset outputs SHALL be: ext_tx_valid 0, cpu_out_full 0, cpu_in_empty 1, ext_rx_ready 1, ext_tx_data don't-care.
REQ-032 Reset mid-transfer SHALL discard all buffered words; first write after release is the first word presented.
REQ-033 FIFO storage array SHALL not require reset.

Configuration
REQ-034 Macro IO_BRIDGE_OVF_STICKY_EN defined: ovf_err SHALL set on any cpu_out_we while cpu_out_full and on ext_rx_valid while FULL for more than 0 cycles is NOT an error; cleared only by reset.
REQ-035 Macro undefined: ovf_err SHALL be tied 0 and no overflow logic compiled.

Verification
REQ-036 Reset: rst low 1 cycle mid-run -> ext_tx_valid 0, cpu_in_empty 1, ext_rx_ready 1, cpu_in_port 0.
REQ-037 Ordering: write 0x0001..0x0004 (DEPTH 4), ext_tx_ready 0 -> cpu_out_full 1; then ready 1 -> pops 0x0001,0x0002,0x0003,0x0004 in order, then valid 0.
REQ-038 Overflow: FIFO full, cpu_out_we with 0xDEAD -> word absent from output; ovf_err 1 with macro, 0 without.
REQ-039 Wrap: 10 writes 0x0010..0x0019 with continuous ext_tx_ready -> all 10 delivered in order, no full.
REQ-040 RX: ext_rx_data 0x0014 valid -> cpu_in_port 0x0014, cpu_in_empty 0, ext_rx_ready 0; second word 0x0015 held off until cpu_in_re, then captured next cycle.
REQ-041 Concurrency: simultaneous write 0x00AA, pop, and RX capture 0x00BB in one cycle -> FIFO count unchanged, cpu_in_port 0x00BB.

Source files
------------

// File: rtl/io_bridge.sv
// io_bridge: CPU <-> external device I/O bridge.
//   TX path: CPU OUT words are queued in a DEPTH-entry circular FIFO and
//            presented to the external device with a valid/ready handshake.
//   RX path: words from the external device land in a one-entry holding
//            register that the CPU drains with an IN strobe.
//
// Optional feature: define IO_BRIDGE_OVF_STICKY_EN to enable the sticky
// overflow flag (set by a CPU OUT strobe while the FIFO is full, cleared
// only by reset). When undefined, ovf_err is tied low.
//
// Ports:
//   clk           in   single clock, rising edge
//   rst           in   asynchronous active-low reset
//   cpu_out_port  in   WIDTH  word written by CPU OUT
//   cpu_out_we    in   CPU OUT strobe, one word per high cycle
//   cpu_out_full  out  FIFO full, CPU stalls OUT while high
//   cpu_in_port   out  WIDTH  word presented to CPU IN
//   cpu_in_re     in   CPU IN consume strobe
//   cpu_in_empty  out  holding register has no valid word
//   ext_tx_data   out  WIDTH  FIFO head word
//   ext_tx_valid  out  ext_tx_data valid (FIFO not empty)
//   ext_tx_ready  in   external device accepts ext_tx_data
//   ext_rx_data   in   WIDTH  word from external device
//   ext_rx_valid  in   ext_rx_data valid
//   ext_rx_ready  out  holding register can accept a word
//   ovf_err       out  sticky overflow flag

module io_bridge #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cpu_out_port,
    input  logic             cpu_out_we,
    output logic             cpu_out_full,
    output logic [WIDTH-1:0] cpu_in_port,
    input  logic             cpu_in_re,
    output logic             cpu_in_empty,
    output logic [WIDTH-1:0] ext_tx_data,
    output logic             ext_tx_valid,
    input  logic             ext_tx_ready,
    input  logic [WIDTH-1:0] ext_rx_data,
    input  logic             ext_rx_valid,
    output logic             ext_rx_ready,
    output logic             ovf_err
);

    // Address bits into storage; pointers carry one extra wrap bit.
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Same address with opposite wrap bit means the writer lapped the reader.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Full blocks the write even if a pop frees a slot in the same cycle.
    assign w_push = cpu_out_we && !w_full;
    assign w_pop  = !w_empty && ext_tx_ready;

    // Pointer registers; natural PW-bit overflow gives wrap modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Storage array, no reset needed: contents are only visible when valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= cpu_out_port;
        end
    end

    assign ext_tx_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign ext_tx_valid = !w_empty;
    assign cpu_out_full = w_full;

    // ------------------------------------------------------------------
    // RX holding register
    // ------------------------------------------------------------------
    typedef enum logic {
        RX_EMPTY = 1'b0,
        RX_FULL  = 1'b1
    } rx_state_t;

    rx_state_t        r_rx_state;
    rx_state_t        w_rx_next;
    logic             w_rx_capture;
    logic [WIDTH-1:0] r_rx_data;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state <= RX_EMPTY;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    // Next state and capture strobe; IN strobe while empty is ignored.
    always_comb begin
        w_rx_next    = r_rx_state;
        w_rx_capture = 1'b0;
        case (r_rx_state)
            RX_EMPTY: begin
                if (ext_rx_valid) begin
                    w_rx_next    = RX_FULL;
                    w_rx_capture = 1'b1;
                end
            end
            RX_FULL: begin
                if (cpu_in_re) begin
                    w_rx_next = RX_EMPTY;
                end
            end
            default: begin
                w_rx_next = RX_EMPTY;
            end
        endcase
    end

    // Captured word; kept after the CPU consumes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_data <= '0;
        end else if (w_rx_capture) begin
            r_rx_data <= ext_rx_data;
        end
    end

    assign cpu_in_port  = r_rx_data;
    assign cpu_in_empty = (r_rx_state == RX_EMPTY);
    assign ext_rx_ready = (r_rx_state == RX_EMPTY);

    // ------------------------------------------------------------------
    // Overflow flag
    // ------------------------------------------------------------------
`ifdef IO_BRIDGE_OVF_STICKY_EN
    logic r_ovf;

    // Sticky: any OUT strobe against a full FIFO sets it until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (cpu_out_we && w_full) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf_err = r_ovf;
`else
    assign ovf_err = 1'b0;
`endif

endmodule
